// File: rtl/fifo_write_control.sv
// Write-side controller for an async FIFO: gates producer writes against full,
// drives the RAM write port, keeps binary/Gray write pointers and produces
// registered full / almost-full / sticky overflow flags against the
// read pointer (already synchronized into this clock domain).
`timescale 1ns/1ps
module fifo_write_control #(
  parameter int a_length  = 3,
  parameter int af_margin = 2
) (
  input  logic                w_ctl_clk,
  input  logic                w_ctl_reset_n,
  input  logic                w_ctl_wr_en_in,
  input  logic [a_length:0]   w_ctl_rd_ptr_gray_in,
  input  logic                w_ctl_ovf_clr_in,
  output logic                w_ctl_mem_we,
  output logic [a_length-1:0] w_ctl_mem_addr,
  output logic [a_length:0]   w_ctl_wr_ptr_bin,
  output logic [a_length:0]   w_ctl_wr_ptr_gray,
  output logic                w_ctl_full,
  output logic                w_ctl_almost_full,
  output logic                w_ctl_overflow,
  output logic [1:0]          w_ctl_state
);
  localparam int PW = a_length + 1;
  localparam logic [PW-1:0] AF_TH = PW'((2 ** a_length) - af_margin);

  typedef enum logic [1:0] {IDLE = 2'b00, ACTIVE = 2'b01, FULL = 2'b10, RSV = 2'b11} state_t;

  state_t          state_q, state_d;
  logic            accept;
  logic [PW-1:0]   bin_q, gray_q;
  logic [PW-1:0]   bin_next, gray_next, rd_bin, occ_next, full_cmp;
  logic            full_next, af_next;
  logic            full_q, af_q, ovf_q;

  assign accept    = w_ctl_wr_en_in & ~full_q;
  assign bin_next  = bin_q + {{a_length{1'b0}}, accept};
  assign gray_next = bin_next ^ (bin_next >> 1);
  // Full pattern: read pointer one lap behind differs in the top two Gray bits
  assign full_cmp  = {~w_ctl_rd_ptr_gray_in[a_length:a_length-1],
                      w_ctl_rd_ptr_gray_in[a_length-2:0]};
  assign full_next = (gray_next == full_cmp);
  assign occ_next  = bin_next - rd_bin;
  assign af_next   = (occ_next >= AF_TH);

  // Gray-to-binary of the synchronized read pointer: bit i is XOR of gray[PW-1:i]
  always_comb begin
    rd_bin = '0;
    for (int i = 0; i < PW; i++) rd_bin[i] = ^(w_ctl_rd_ptr_gray_in >> i);
  end

  // Pointer and flag registers; overflow set wins over clear
  always_ff @(posedge w_ctl_clk or negedge w_ctl_reset_n) begin
    if (!w_ctl_reset_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      full_q <= 1'b0;
      af_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      bin_q  <= bin_next;
      gray_q <= gray_next;
      full_q <= full_next;
      af_q   <= af_next;
      if (w_ctl_wr_en_in & full_q) ovf_q <= 1'b1;
      else if (w_ctl_ovf_clr_in)   ovf_q <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge w_ctl_clk or negedge w_ctl_reset_n) begin
    if (!w_ctl_reset_n) state_q <= IDLE;
    else                state_q <= state_d;
  end

  // FSM next-state: tracks the full value being registered on this edge
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = full_next ? FULL : (accept ? ACTIVE : IDLE);
      ACTIVE:  state_d = full_next ? FULL : (accept ? ACTIVE : IDLE);
      FULL:    state_d = full_next ? FULL : (accept ? ACTIVE : IDLE);
      default: state_d = IDLE;
    endcase
  end

  // Outputs: write enable is zero-latency from the request
  always_comb begin
    w_ctl_mem_we      = accept;
    w_ctl_mem_addr    = bin_q[a_length-1:0];
    w_ctl_wr_ptr_bin  = bin_q;
    w_ctl_wr_ptr_gray = gray_q;
    w_ctl_full        = full_q;
    w_ctl_almost_full = af_q;
    w_ctl_overflow    = ovf_q;
    w_ctl_state       = state_q;
  end
endmodule

// File: doc/fifo_write_control.md
Name: fifo_write_control

Overview:
- Write-side controller for the async FIFO.
- Accepts write requests from the producer and gates them against the full condition.
- Drives the dual-port RAM write enable and address, and maintains the binary and Gray write pointers (pointer width = address width + 1 wrap bit).
- Generates registered full, almost-full and sticky overflow flags by comparing against the read pointer, which arrives already synchronized into the write clock domain.

Parameters:
- a_length, 3, address width; FIFO depth = 2^a_length; pointers are a_length+1 bits; legal range >= 2.
- af_margin, 2, almost-full threshold: asserted when occupancy >= 2^a_length - af_margin; range 1..2^a_length-1.

Ports:
- w_ctl_clk  input  1  write-domain clock, rising edge.
- w_ctl_reset_n  input  1  asynchronous, active-low reset.
- w_ctl_wr_en_in  input  1  producer write request, one word per cycle.
- w_ctl_rd_ptr_gray_in  input  a_length+1  read pointer (Gray), already synchronized to w_ctl_clk.
- w_ctl_ovf_clr_in  input  1  clears the sticky overflow flag.
- w_ctl_mem_we  output  1  RAM write enable (combinational).
- w_ctl_mem_addr  output  a_length  RAM write address = w_ctl_wr_ptr_bin[a_length-1:0].
- w_ctl_wr_ptr_bin  output  a_length+1  binary write pointer (registered).
- w_ctl_wr_ptr_gray  output  a_length+1  Gray write pointer (registered), sent to the read domain.
- w_ctl_full  output  1  FIFO full (registered).
- w_ctl_almost_full  output  1  occupancy at or above threshold (registered).
- w_ctl_overflow  output  1  sticky: a write was attempted while full.
- w_ctl_state  output  2  FSM state, for debug/status.

Behaviour:
- Reset (asynchronous, w_ctl_reset_n = 0):
  - w_ctl_wr_ptr_bin = 0, w_ctl_wr_ptr_gray = 0.
  - w_ctl_full = 0, w_ctl_almost_full = 0, w_ctl_overflow = 0.
  - w_ctl_state = IDLE (2'b00).
  - w_ctl_mem_we follows its combinational equation (0 while w_ctl_wr_en_in = 0).
  - Reset mid-operation discards all pointer and flag state immediately, with no wait for a clock edge.
- Accept: accept = w_ctl_wr_en_in & ~w_ctl_full.
  - w_ctl_mem_we = accept; zero-latency, same cycle as the request.
  - The RAM captures the data at the current w_ctl_mem_addr.
- Pointer update:
  - bin_next = w_ctl_wr_ptr_bin + accept, modulo 2^(a_length+1); wraps from all-ones to 0.
  - gray_next = bin_next ^ (bin_next >> 1).
  - Both pointers register on the rising edge, so w_ctl_wr_ptr_gray always equals the Gray code of w_ctl_wr_ptr_bin.
- Full:
  - w_ctl_full <= (gray_next == {~rd_gray[a_length:a_length-1], rd_gray[a_length-2:0]}).
  - Full asserts on the same edge that accepts the 2^a_length-th outstanding word.
  - Full deasserts one cycle after w_ctl_rd_ptr_gray_in advances.
- Almost-full:
  - rd_bin = Gray-to-binary of w_ctl_rd_ptr_gray_in, computed combinationally.
  - occ_next = bin_next - rd_bin, modulo 2^(a_length+1).
  - w_ctl_almost_full <= (occ_next >= 2^a_length - af_margin).
- Overflow:
  - Set on the edge where w_ctl_wr_en_in & w_ctl_full.
  - Otherwise cleared on the edge where w_ctl_ovf_clr_in = 1.
  - Set has priority over clear in the same cycle.
  - An overflowed write never moves the pointer and never asserts w_ctl_mem_we.
- FSM (registered, evaluated each edge):
  - IDLE (00): go to FULL if next full; else ACTIVE if accept; else stay.
  - ACTIVE (01): go to FULL if next full; else stay if accept; else IDLE.
  - FULL (10): go to ACTIVE if next full = 0 and accept; go to IDLE if next full = 0 and no accept; else stay.
  - Encoding 11 is unreachable and recovers to IDLE.
  - "next full" means the value being registered into w_ctl_full on that edge.
- Simultaneous events:
  - A write accepted in the same cycle the read pointer advances uses both updated values for the full and almost-full computation.
  - No write is ever lost or double-counted.

Test Plan:
- Reset, a_length = 3, rd_gray = 0, and 8 back-to-back writes:
  - w_ctl_mem_addr steps 0..7, with mem_we high on all 8 cycles.
  - After the 8th edge: bin = 4'b1000, gray = 4'b1100, full = 1, state = FULL.
  - almost_full = 1 from the edge of the 6th write.
- Continue from that full state with a 9th write:
  - mem_we = 0 and the pointer holds at 4'b1000.
  - overflow = 1 next edge; it stays 1 until ovf_clr; ovf_clr asserted together with a new overflow event leaves overflow = 1.
- From full, drive rd_gray = 4'b0001 (rd_bin = 1):
  - full = 0 one cycle later and state = IDLE.
  - A following write sets full again with bin = 4'b1001.
- Wrap-around: 20 writes with rd_gray tracking wr_gray one cycle later:
  - bin passes 4'b1111 -> 4'b0000 and gray passes 4'b1000 -> 4'b0000.
  - full never asserts and overflow = 0.
- Assert reset after 5 writes with wr_en held high:
  - All outputs return to their reset values without a clock edge.
  - First accepted write after release targets address 0.
- af_margin = 1: almost_full first asserts on the edge of the 7th write.
